// File: rtl/race_sequencer_if.sv
// Race sequencer bus: start/acknowledge, player positions in, race status out.
interface race_sequencer_if;
    logic       start_req;
    logic [9:0] p1_x, p1_y, p2_x, p2_y;
    logic [2:0] state;
    logic       restart_pulse;
    logic [2:0] p1_lap, p2_lap;
    logic [1:0] winner;
    logic [7:0] race_time;

    modport master (
        output start_req, p1_x, p1_y, p2_x, p2_y,
        input  state, restart_pulse, p1_lap, p2_lap, winner, race_time
    );
    modport slave (
        input  start_req, p1_x, p1_y, p2_x, p2_y,
        output state, restart_pulse, p1_lap, p2_lap, winner, race_time
    );
endinterface

// File: rtl/race_sequencer.sv
// Two-player race control: 3-2-1 countdown, checkpoint-armed lap counting,
// winner detection and a saturating seconds clock.
module race_sequencer #(
    parameter int TICK_CYCLES = 100000000,
    parameter int LAPS        = 3,
    parameter int FIN_X0      = 0,
    parameter int FIN_X1      = 39,
    parameter int FIN_Y0      = 110,
    parameter int FIN_Y1      = 119,
    parameter int CP_X0       = 280,
    parameter int CP_X1       = 319,
    parameter int CP_Y0       = 110,
    parameter int CP_Y1       = 129
) (
    input logic              clk,
    input logic              rst,
    race_sequencer_if.slave  bus
);
    localparam int             TW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [2:0]     LAPS_W    = 3'(LAPS);

    typedef enum logic [2:0] {
        IDLE = 3'd0, COUNT3 = 3'd1, COUNT2 = 3'd2, COUNT1 = 3'd3,
        RACING = 3'd4, FINISH = 3'd5
    } state_t;

    // Bounds come in as ports so constant-zero bounds don't become constant compares.
    function automatic logic in_zone(input logic [9:0] x, y, x0, x1, y0, y1);
        return (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);
    endfunction

    state_t          st;
    logic [TW-1:0]   tick;
    logic            rp;
    logic [2:0]      lap1, lap2;
    logic [1:0]      win;
    logic [7:0]      rtime;
    logic            arm1, arm2, pf1, pf2;

    logic fin1, fin2, cp1, cp2, racing, wrap, hit1, hit2, done1, done2;

    assign fin1   = in_zone(bus.p1_x, bus.p1_y, 10'(FIN_X0), 10'(FIN_X1), 10'(FIN_Y0), 10'(FIN_Y1));
    assign fin2   = in_zone(bus.p2_x, bus.p2_y, 10'(FIN_X0), 10'(FIN_X1), 10'(FIN_Y0), 10'(FIN_Y1));
    assign cp1    = in_zone(bus.p1_x, bus.p1_y, 10'(CP_X0), 10'(CP_X1), 10'(CP_Y0), 10'(CP_Y1));
    assign cp2    = in_zone(bus.p2_x, bus.p2_y, 10'(CP_X0), 10'(CP_X1), 10'(CP_Y0), 10'(CP_Y1));
    assign racing = (st == RACING);
    assign wrap   = (tick == TICK_LAST);
    // A lap counts only on a fresh, armed entry into the finish zone.
    assign hit1   = racing && fin1 && !pf1 && arm1 && (lap1 != LAPS_W);
    assign hit2   = racing && fin2 && !pf2 && arm2 && (lap2 != LAPS_W);
    assign done1  = hit1 && ((lap1 + 3'd1) == LAPS_W);
    assign done2  = hit2 && ((lap2 + 3'd1) == LAPS_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st    <= IDLE;
            tick  <= '0;
            rp    <= 1'b0;
            lap1  <= '0;
            lap2  <= '0;
            win   <= '0;
            rtime <= '0;
            arm1  <= 1'b0;
            arm2  <= 1'b0;
            pf1   <= 1'b0;
            pf2   <= 1'b0;
        end else begin
            rp  <= 1'b0;
            pf1 <= fin1;
            pf2 <= fin2;
            case (st)
                IDLE: begin
                    tick <= '0;
                    if (bus.start_req) begin
                        st    <= COUNT3;
                        rp    <= 1'b1;
                        lap1  <= '0;
                        lap2  <= '0;
                        win   <= '0;
                        rtime <= '0;
                        arm1  <= 1'b0;
                        arm2  <= 1'b0;
                    end
                end
                COUNT3, COUNT2, COUNT1: begin
                    if (wrap) begin
                        tick <= '0;
                        st   <= (st == COUNT3) ? COUNT2 : (st == COUNT2) ? COUNT1 : RACING;
                    end else begin
                        tick <= tick + TW'(1);
                    end
                end
                RACING: begin
                    tick <= wrap ? '0 : tick + TW'(1);
                    if (wrap && rtime != 8'hFF) rtime <= rtime + 8'd1;
                    if (hit1)     begin lap1 <= lap1 + 3'd1; arm1 <= 1'b0; end
                    else if (cp1) arm1 <= 1'b1;
                    if (hit2)     begin lap2 <= lap2 + 3'd1; arm2 <= 1'b0; end
                    else if (cp2) arm2 <= 1'b1;
                    if (done1 || done2) begin
                        st   <= FINISH;
                        tick <= '0;
                        win  <= {done2, done1};
                    end
                end
                FINISH: begin
                    tick <= '0;
                    if (bus.start_req) st <= IDLE;
                end
                default: begin
                    st   <= IDLE;
                    tick <= '0;
                end
            endcase
        end
    end

    assign bus.state         = st;
    assign bus.restart_pulse = rp;
    assign bus.p1_lap        = lap1;
    assign bus.p2_lap        = lap2;
    assign bus.winner        = win;
    assign bus.race_time     = rtime;
endmodule

// File: tb/tb_race_sequencer.sv
// Directed bench for race_sequencer with TICK_CYCLES=4, LAPS=2.
module tb_race_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    race_sequencer_if bus();

    race_sequencer #(.TICK_CYCLES(4), .LAPS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pos1(input int x, input int y);
        bus.p1_x = 10'(x);
        bus.p1_y = 10'(y);
    endtask

    task automatic pos2(input int x, input int y);
        bus.p2_x = 10'(x);
        bus.p2_y = 10'(y);
    endtask

    task automatic pulse_start();
        bus.start_req = 1'b1;
        step(1);
        bus.start_req = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_state"}, int'(bus.state), 0);
        chk({tag, "_rp"},    int'(bus.restart_pulse), 0);
        chk({tag, "_lap1"},  int'(bus.p1_lap), 0);
        chk({tag, "_lap2"},  int'(bus.p2_lap), 0);
        chk({tag, "_win"},   int'(bus.winner), 0);
        chk({tag, "_time"},  int'(bus.race_time), 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.start_req = 1'b0;
        pos1(150, 50);
        pos2(150, 60);
        #2;
        chk_zero("reset");
        step(2);
        rst = 1'b0;
        step(3);
        chk("idle_hold", int'(bus.state), 0);

        // Countdown timing, start ignored mid-countdown
        pulse_start();                                   // E0
        chk("e0_state", int'(bus.state), 1);
        chk("e0_rp", int'(bus.restart_pulse), 1);
        step(1);                                         // E1
        chk("e1_rp", int'(bus.restart_pulse), 0);
        chk("e1_state", int'(bus.state), 1);
        step(2);                                         // E3
        chk("e3_state", int'(bus.state), 1);
        step(1);                                         // E4
        chk("e4_state", int'(bus.state), 2);
        pulse_start();                                   // E5
        chk("ign_state", int'(bus.state), 2);
        chk("ign_rp", int'(bus.restart_pulse), 0);
        step(3);                                         // E8
        chk("e8_state", int'(bus.state), 3);
        step(3);                                         // E11
        chk("e11_state", int'(bus.state), 3);
        step(1);                                         // E12
        chk("go_state", int'(bus.state), 4);
        chk("go_time", int'(bus.race_time), 0);

        // P1 wins two laps; P2 sits unarmed in the finish zone
        pos2(20, 112);
        pos1(300, 120);
        step(1);                                         // E13
        pos1(10, 115);
        step(1);                                         // E14
        chk("lap1_first", int'(bus.p1_lap), 1);
        chk("lap1_state", int'(bus.state), 4);
        step(1);                                         // E15
        chk("lap1_stay", int'(bus.p1_lap), 1);
        pos1(150, 50);
        step(7);                                         // E22
        chk("p2_unarmed", int'(bus.p2_lap), 0);
        chk("time_e22", int'(bus.race_time), 2);
        pos1(300, 120);
        step(1);                                         // E23
        pos1(10, 115);
        step(1);                                         // E24
        chk("win_lap", int'(bus.p1_lap), 2);
        chk("win_state", int'(bus.state), 5);
        chk("win_who", int'(bus.winner), 1);
        chk("win_time", int'(bus.race_time), 3);
        step(5);
        chk("frz_time", int'(bus.race_time), 3);
        chk("frz_state", int'(bus.state), 5);
        pos1(300, 120); step(1);
        pos1(150, 50);  step(1);
        pos1(10, 115);  step(1);
        chk("frz_lap", int'(bus.p1_lap), 2);
        chk("frz_lap2", int'(bus.p2_lap), 0);
        pulse_start();
        chk("fin_idle", int'(bus.state), 0);
        chk("fin_rp", int'(bus.restart_pulse), 0);
        chk("fin_keepwin", int'(bus.winner), 1);
        pos1(150, 50);
        pos2(150, 60);

        // Tie on the deciding lap
        pulse_start();
        chk("tie_rp", int'(bus.restart_pulse), 1);
        chk("tie_clrwin", int'(bus.winner), 0);
        chk("tie_clrlap", int'(bus.p1_lap), 0);
        step(12);
        chk("tie_go", int'(bus.state), 4);
        pos1(300, 120); pos2(310, 125); step(1);
        pos1(10, 115);  pos2(30, 118);  step(1);
        chk("tie_l1a", int'(bus.p1_lap), 1);
        chk("tie_l1b", int'(bus.p2_lap), 1);
        chk("tie_l1w", int'(bus.winner), 0);
        pos1(150, 50);  pos2(150, 60);  step(1);
        pos1(280, 110); pos2(319, 129); step(1);
        pos1(0, 110);   pos2(39, 119);  step(1);
        chk("tie_win", int'(bus.winner), 3);
        chk("tie_state", int'(bus.state), 5);
        chk("tie_l2a", int'(bus.p1_lap), 2);
        chk("tie_l2b", int'(bus.p2_lap), 2);
        pos1(150, 50);  pos2(150, 60);
        pulse_start();
        chk("tie_idle", int'(bus.state), 0);

        // Saturating race clock, then async reset mid-race
        pulse_start();
        step(12);
        step(1100);
        chk("sat_time", int'(bus.race_time), 255);
        chk("sat_state", int'(bus.state), 4);
        rst = 1'b1;
        #1;
        chk_zero("rst_race");
        #2;
        rst = 1'b0;
        step(3);
        chk("rst_race_hold", int'(bus.state), 0);

        // Async reset mid-COUNT2
        pulse_start();
        step(5);
        chk("c2_state", int'(bus.state), 2);
        rst = 1'b1;
        #1;
        chk_zero("rst_c2");
        #2;
        rst = 1'b0;
        step(2);
        chk("rst_c2_hold", int'(bus.state), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/race_sequencer.md
RACE_SEQUENCER -- requirements
Module: race_sequencer

Interface
REQ-001 SHALL provide parameter TICK_CYCLES, default 100000000, clk cycles per one-second tick.
REQ-002 SHALL provide parameter LAPS, default 3, laps to win (range 1..7).
REQ-003 SHALL provide parameters FIN_X0/FIN_X1/FIN_Y0/FIN_Y1, defaults 0/39/110/119, inclusive finish-zone world bounds.
REQ-004 SHALL provide parameters CP_X0/CP_X1/CP_Y0/CP_Y1, defaults 280/319/110/129, inclusive checkpoint-zone world bounds.
REQ-005 SHALL have clk  input  1  system clock; all state changes on its rising edge.
REQ-006 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have start_req  input  1  one-cycle start/acknowledge pulse, clk domain.
REQ-008 SHALL have p1_x, p1_y, p2_x, p2_y  input  10 each  player world positions.
REQ-009 SHALL have state  output  3  race state, drives physics and operation encoders.
REQ-010 SHALL have restart_pulse  output  1  one-cycle pulse re-initialising physics engines.
REQ-011 SHALL have p1_lap, p2_lap  output  3 each  completed laps.
REQ-012 SHALL have winner  output  2  0 none, 1 P1, 2 P2, 3 tie.
REQ-013 SHALL have race_time  output  8  elapsed racing seconds.

Function
REQ-014 State encoding SHALL be IDLE=0, COUNT3=1, COUNT2=2, COUNT1=3, RACING=4, FINISH=5; 6/7 unreachable, recover to IDLE next cycle.
REQ-015 All outputs SHALL be registered.
REQ-016 IDLE + start_req -> COUNT3 at that edge; restart_pulse=1 for exactly that next cycle; laps, winner, race_time, checkpoint flags cleared at the same edge.
REQ-017 Tick counter SHALL be 0 in IDLE/FINISH, clear on every state transition, count 0..TICK_CYCLES-1 in states 1..4.
REQ-018 Each of COUNT3, COUNT2, COUNT1 SHALL last exactly TICK_CYCLES cycles, then advance 1->2->3->4.
REQ-019 In RACING, race_time SHALL increment on each tick-counter wrap, saturating at 255.
REQ-020 start_req SHALL be ignored in states 1..4.
REQ-021 Zone membership: in_zone = X0<=x<=X1 and Y0<=y<=Y1, unsigned compare, per player.
REQ-022 Per player, armed flag SHALL set when inside checkpoint zone during RACING; cleared at race start and on lap count.
REQ-023 Lap SHALL increment (visible next cycle) only in RACING, on the cycle the player is in finish zone, was not in finish zone the previous cycle, and armed=1; armed clears at that edge.
REQ-024 Finish-zone entry without armed SHALL NOT count; remaining inside zone SHALL NOT re-count.
REQ-025 Previous-cycle finish-zone flags SHALL be sampled in all states so a player resting in zone at GO does not count.
REQ-026 When a lap increment brings a player to LAPS, state SHALL become FINISH at that same edge with winner set (1 or 2); both at the same edge -> winner=3.
REQ-027 FINISH: laps, winner, race_time frozen; start_req -> IDLE (no restart_pulse); winner retained until next race start.
REQ-028 Lap counters SHALL never exceed LAPS.

Reset
REQ-029 rst asserted SHALL immediately force state=IDLE, restart_pulse=0, laps=0, winner=0, race_time=0, tick counter=0, armed=0, previous-zone flags=0, regardless of state.
REQ-030 After rst deassertion, block SHALL remain IDLE until start_req.

Verification (TICK_CYCLES=4, LAPS=2)
REQ-031 start_req in IDLE -> restart_pulse high one cycle; state 1,2,3 for 4 cycles each, then 4.
REQ-032 RACING, P1 enters checkpoint then finish twice -> p1_lap 1 then 2, state=5, winner=1, race_time frozen.
REQ-033 P2 enters finish zone without checkpoint, stays 10 cycles -> p2_lap remains 0.
REQ-034 Both players complete lap 2 on same cycle -> winner=3, state=5.
REQ-035 RACING for 1100 cycles -> race_time=255 saturated, not wrapped.
REQ-036 rst mid-COUNT2 and mid-RACING -> all outputs zero, state=0 without waiting for clk; start_req in FINISH -> IDLE.
